debounce_array: RTL and testbench
=================================

// Module: debounce_array
// PURPOSE
//  Parametrised multi-channel input debouncer with an Avalon-MM slave. Successor to the
//  per-button single-channel debouncers in trolley_system. Synchronises N raw inputs
//  (buttons, key, proximity sensor) and filters each one with its own counter. Captures
//  enabled rise/fall events and raises a maskable level IRQ to the Nios II.
// PARAMETERS
//  CHANNELS         8      number of inputs, 1..16
//  CNT_W            16     debounce counter width; DEBOUNCE_CYCLES must be < 2**CNT_W
//  DEBOUNCE_CYCLES  50000  consecutive cycles of changed input before acceptance (1 ms @ 50 MHz)
//  SYNC_STAGES      2      synchroniser flops per channel, >= 2
// PORTS
//  clk_clk          in   1         system clock
//  reset_reset_n    in   1         async active-low reset
//  raw_in           in   CHANNELS  asynchronous raw inputs
//  debounced_out    out  CHANNELS  filtered levels
//  avs_address      in   2         word address
//  avs_read         in   1         read strobe
//  avs_write        in   1         write strobe
//  avs_writedata    in   32        write data
//  avs_readdata     out  32        read data, registered; read latency 1
//  irq              out  1         level interrupt, registered
// BEHAVIOUR
//  Reset (async assert, sync release): all sync flops, stable states, counters, EDGE,
//   MASK and readdata = 0. RISE_EN = FALL_EN = all ones. irq = 0. debounced_out = 0.
//  Per channel, on sync_out = last synchroniser stage:
//   - sync_out == stable: count <= 0.
//   - sync_out != stable and count == DEBOUNCE_CYCLES-1: stable <= sync_out, count <= 0,
//     and a 1-cycle rise or fall pulse fires.
//   - otherwise: count <= count + 1.
//   - A glitch shorter than DEBOUNCE_CYCLES clears the count and produces no change.
//   - Latency from a clean raw edge to debounced_out: SYNC_STAGES + DEBOUNCE_CYCLES clocks.
//  Register map (offsets 0-3):
//   0 STATE  RO. [CHANNELS-1:0] = stable levels. Writes ignored.
//   1 EDGE   W1C. Bit i is set by a rise pulse when RISE_EN[i] = 1, or by a fall pulse
//            when FALL_EN[i] = 1. A set event in the same cycle as a W1C to that bit: set wins.
//   2 MASK   RW. [CHANNELS-1:0] interrupt enables.
//   3 EDGECFG RW. [15:0] = RISE_EN, [31:16] = FALL_EN. Bits at and above CHANNELS in
//            each half read 0 and ignore writes.
//  Unused upper bits in every register read as 0.
//  avs_readdata updates one cycle after avs_read and holds its value otherwise.
//  Read of EDGE has no side effect.
//  irq <= |(EDGE & MASK), registered, so irq follows the EDGE bit set by one cycle.
//  Read and write in the same cycle: the write is applied and readdata returns the
//   pre-write value.
//  No wait states. The slave never stalls.
// STRUCTURE
//  debounce_pkg:
//   - localparams REG_STATE = 2'd0, REG_EDGE = 2'd1, REG_MASK = 2'd2, REG_EDGECFG = 2'd3
//   - function clog2
//  Sub-module debounce_channel (one per channel, generate loop):
//   - ports: clk_clk, reset_reset_n, raw, stable, rise, fall
//   - parameters: CNT_W, DEBOUNCE_CYCLES, SYNC_STAGES
//  Top level holds the register file, edge capture, IRQ and read mux.
// TESTING (bench uses DEBOUNCE_CYCLES=16, CHANNELS=4, SYNC_STAGES=2)
//  1. Reset: hold reset_reset_n=0 with raw_in=4'hF -> debounced_out=0, irq=0,
//     EDGECFG reads 0x000F000F.
//  2. Step raw_in[0] 0->1 and hold -> debounced_out[0] rises exactly 18 clocks later;
//     EDGE reads 0x1.
//  3. Pulse raw_in[1] high for 15 clocks -> no change on debounced_out[1]; EDGE stays 0.
//  4. Interrupt path, on ch2:
//     a. MASK=0x4, then a debounced fall on ch2 -> irq=1 one clock after EDGE[2] sets.
//     b. Write EDGE=0x4 -> irq=0 after 1 clock.
//  5. Simultaneous set and clear: EDGECFG=0x00000008, then align a W1C of EDGE[3] with
//     the ch3 rise pulse -> EDGE[3] reads 1.
//  6. Mid-filter reset: assert reset_reset_n during a count of 10 -> state, counter and
//     EDGE return to 0; after release, raw held high gives a full 18-clock latency again.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared register offsets and helpers for the multi-channel debouncer.
// No logic of its own; imported by the channel filter and the register top.
package debounce_pkg;

  localparam logic [1:0] REG_STATE   = 2'd0;
  localparam logic [1:0] REG_EDGE    = 2'd1;
  localparam logic [1:0] REG_MASK    = 2'd2;
  localparam logic [1:0] REG_EDGECFG = 2'd3;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input: synchroniser chain plus a consecutive-cycle filter; the level is accepted
// SYNC_STAGES + DEBOUNCE_CYCLES clocks after a clean raw edge, never stalls.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   accept;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign accept   = (sync_out != stable_q) && (cnt_q == LIMIT);

  // Any cycle where the synchronised input matches the accepted level restarts the filter.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_out == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LIMIT) begin
      stable_d = sync_out;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = accept & sync_out;
  assign fall   = accept & ~sync_out;

endmodule

// File: rtl/debounce_array.sv
// Debouncer array with Avalon-MM register file, W1C edge capture and level IRQ.
// Read latency 1, irq one clock behind EDGE; zero wait states, the slave never stalls.
module debounce_array
  import debounce_pkg::*;
#(
  parameter int CHANNELS        = 8,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] debounced_out,
  input  logic [1:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic                irq
);

  logic [1:0]          rst_sync_q;
  logic                rst_n;
  logic [CHANNELS-1:0] stable_w, rise_w, fall_w;
  logic [CHANNELS-1:0] edge_q, edge_d, mask_q, mask_d;
  logic [CHANNELS-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [31:0]         readdata_q, readdata_d;
  logic                irq_q, irq_d;
  logic                unused_wdata;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) rst_sync_q <= '0;
    else                rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .clk_clk      (clk_clk),
      .reset_reset_n(rst_n),
      .raw          (raw_in[i]),
      .stable       (stable_w[i]),
      .rise         (rise_w[i]),
      .fall         (fall_w[i])
    );
  end

  always_comb begin
    edge_d     = edge_q;
    mask_d     = mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    readdata_d = readdata_q;
    if (avs_write) begin
      case (avs_address)
        REG_EDGE:    edge_d    = edge_q & ~avs_writedata[CHANNELS-1:0];
        REG_MASK:    mask_d    = avs_writedata[CHANNELS-1:0];
        REG_EDGECFG: begin
          rise_en_d = avs_writedata[CHANNELS-1:0];
          fall_en_d = avs_writedata[16 +: CHANNELS];
        end
        default: ;
      endcase
    end
    // A new event beats a simultaneous clear of the same bit.
    edge_d = edge_d | (rise_w & rise_en_q) | (fall_w & fall_en_q);
    // Reads see register contents before any same-cycle write.
    if (avs_read) begin
      readdata_d = '0;
      case (avs_address)
        REG_STATE:   readdata_d[CHANNELS-1:0] = stable_w;
        REG_EDGE:    readdata_d[CHANNELS-1:0] = edge_q;
        REG_MASK:    readdata_d[CHANNELS-1:0] = mask_q;
        REG_EDGECFG: begin
          readdata_d[CHANNELS-1:0]   = rise_en_q;
          readdata_d[16 +: CHANNELS] = fall_en_q;
        end
        default: ;
      endcase
    end
    irq_d = |(edge_q & mask_q);
  end

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q     <= '0;
      mask_q     <= '0;
      rise_en_q  <= '1;
      fall_en_q  <= '1;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign unused_wdata  = ^avs_writedata;
  assign debounced_out = stable_w;
  assign avs_readdata  = readdata_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_debounce_array.sv
// Bench for debounce_array: 4 channels, 16-cycle filter, 2 sync stages.
module tb_debounce_array;
  import debounce_pkg::*;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [3:0]  raw_in;
  logic [3:0]  debounced_out;
  logic [1:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        irq;

  debounce_array #(
    .CHANNELS(4), .CNT_W(16), .DEBOUNCE_CYCLES(16), .SYNC_STAGES(2)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .raw_in(raw_in),
    .debounced_out(debounced_out), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] exp;
    int          tag;
  } sb_t;
  sb_t sb_q[$];
  logic sb_rd = 1'b0;
  logic rd_pend = 1'b0;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  // Drives one bus cycle; a read's expected value goes to the scoreboard.
  task automatic bus(input bit wr, input bit rd, input logic [1:0] a,
                     input logic [31:0] wd, input logic [31:0] exp, input int tag);
    avs_address   = a;
    avs_write     = wr;
    avs_writedata = wd;
    avs_read      = rd;
    sb_rd         = rd;
    if (rd) sb_q.push_back('{exp: exp, tag: tag});
    tick();
    avs_write = 1'b0;
    avs_read  = 1'b0;
    sb_rd     = 1'b0;
  endtask

  always @(posedge clk_clk) rd_pend <= sb_rd;

  always @(negedge clk_clk) begin
    if (rd_pend) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check($sformatf("read_tag%0d", e.tag), avs_readdata, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic found;
    logic prev_irq;

    vecs[0]  = '{0, 1, REG_STATE,   32'h0,        32'h0};
    vecs[1]  = '{0, 1, REG_EDGE,    32'h0,        32'h0};
    vecs[2]  = '{0, 1, REG_MASK,    32'h0,        32'h0};
    vecs[3]  = '{0, 1, REG_EDGECFG, 32'h0,        32'h000F000F};
    vecs[4]  = '{1, 0, REG_MASK,    32'hFFFFFFFF, 32'h0};
    vecs[5]  = '{0, 1, REG_MASK,    32'h0,        32'h0000000F};
    vecs[6]  = '{1, 0, REG_EDGECFG, 32'hFFFFFFFF, 32'h0};
    vecs[7]  = '{0, 1, REG_EDGECFG, 32'h0,        32'h000F000F};
    vecs[8]  = '{1, 0, REG_EDGECFG, 32'h00050003, 32'h0};
    vecs[9]  = '{0, 1, REG_EDGECFG, 32'h0,        32'h00050003};
    vecs[10] = '{1, 0, REG_STATE,   32'hFFFFFFFF, 32'h0};
    vecs[11] = '{0, 1, REG_STATE,   32'h0,        32'h0};
    vecs[12] = '{1, 0, REG_EDGE,    32'hFFFFFFFF, 32'h0};
    vecs[13] = '{0, 1, REG_EDGE,    32'h0,        32'h0};
    vecs[14] = '{1, 0, REG_MASK,    32'h0,        32'h0};
    vecs[15] = '{1, 0, REG_EDGECFG, 32'hFFFFFFFF, 32'h0};
    vecs[16] = '{0, 1, REG_EDGECFG, 32'h0,        32'h000F000F};

    // Reset with all raw inputs high
    reset_reset_n = 1'b0;
    raw_in        = 4'hF;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    repeat (5) tick();
    check("rst_debounced", 32'(debounced_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_readdata", avs_readdata, 32'h0);
    raw_in = 4'h0;
    reset_reset_n = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 17; i++)
      bus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].exp, i);
    check("regs_irq_idle", 32'(irq), 32'h0);

    // Clean rise on ch0: exactly 18 clocks
    raw_in[0] = 1'b1;
    repeat (17) tick();
    check("ch0_before_18", 32'(debounced_out[0]), 32'h0);
    tick();
    check("ch0_at_18", 32'(debounced_out[0]), 32'h1);
    repeat (3) tick();
    bus(0, 1, REG_EDGE, 0, 32'h1, 100);
    bus(0, 1, REG_STATE, 0, 32'h1, 101);
    bus(1, 0, REG_EDGE, 32'h1, 0, 0);
    bus(0, 1, REG_EDGE, 0, 32'h0, 102);

    // 15-clock glitch on ch1 is rejected
    seen = 1'b0;
    raw_in[1] = 1'b1;
    repeat (15) begin tick(); seen |= debounced_out[1]; end
    raw_in[1] = 1'b0;
    repeat (25) begin tick(); seen |= debounced_out[1]; end
    check("ch1_glitch", 32'(seen), 32'h0);
    bus(0, 1, REG_EDGE, 0, 32'h0, 103);

    // Interrupt on ch2 fall
    raw_in[2] = 1'b1;
    repeat (25) tick();
    check("ch2_high", 32'(debounced_out[2]), 32'h1);
    bus(1, 0, REG_EDGE, 32'h4, 0, 0);
    bus(0, 1, REG_EDGE, 0, 32'h0, 104);
    bus(1, 0, REG_MASK, 32'h4, 0, 0);
    repeat (2) tick();
    check("ch2_irq_idle", 32'(irq), 32'h0);
    raw_in[2]   = 1'b0;
    avs_address = REG_EDGE;
    avs_read    = 1'b1;
    found       = 1'b0;
    prev_irq    = irq;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_clk);
      if (avs_readdata[2]) begin
        found = 1'b1;
        check("irq_after_edge", 32'(irq), 32'h1);
        check("irq_low_before_edge", 32'(prev_irq), 32'h0);
      end
      prev_irq = irq;
    end
    check("ch2_edge_seen", 32'(found), 32'h1);
    tick();
    avs_read = 1'b0;
    bus(1, 0, REG_EDGE, 32'h4, 0, 0);
    check("irq_hold_clear_cycle", 32'(irq), 32'h1);
    tick();
    check("irq_cleared", 32'(irq), 32'h0);
    bus(1, 0, REG_MASK, 32'h0, 0, 0);

    // Set beats a same-cycle clear on ch3
    bus(1, 0, REG_EDGECFG, 32'h00000008, 0, 0);
    bus(0, 1, REG_EDGECFG, 0, 32'h00000008, 105);
    raw_in[3] = 1'b1;
    repeat (17) tick();
    bus(1, 0, REG_EDGE, 32'h8, 0, 0);
    check("ch3_high", 32'(debounced_out[3]), 32'h1);
    bus(0, 1, REG_EDGE, 0, 32'h8, 106);
    bus(1, 0, REG_EDGE, 32'h8, 0, 0);
    bus(0, 1, REG_EDGE, 0, 32'h0, 107);
    raw_in[3] = 1'b0;
    repeat (25) tick();
    bus(0, 1, REG_EDGE, 0, 32'h0, 108);
    raw_in[3] = 1'b1;
    repeat (25) tick();
    bus(0, 1, REG_EDGE, 0, 32'h8, 109);

    // Read and write of MASK in the same cycle returns the old value
    bus(1, 1, REG_MASK, 32'h3, 32'h0, 110);
    bus(0, 1, REG_MASK, 0, 32'h3, 111);

    // Reset in the middle of a ch1 count of 10
    raw_in[1] = 1'b1;
    repeat (12) tick();
    reset_reset_n = 1'b0;
    raw_in = 4'h0;
    #1;
    check("midrst_debounced", 32'(debounced_out), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    repeat (3) tick();
    reset_reset_n = 1'b1;
    repeat (5) tick();
    bus(0, 1, REG_EDGE, 0, 32'h0, 112);
    bus(0, 1, REG_STATE, 0, 32'h0, 113);
    bus(0, 1, REG_MASK, 0, 32'h0, 114);
    bus(0, 1, REG_EDGECFG, 0, 32'h000F000F, 115);
    raw_in[1] = 1'b1;
    repeat (17) tick();
    check("ch1_post_rst_before_18", 32'(debounced_out[1]), 32'h0);
    tick();
    check("ch1_post_rst_at_18", 32'(debounced_out[1]), 32'h1);

    repeat (3) tick();
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
